adc_current_monitor: RTL and testbench

//  Parametrised successor to the single-channel ADC current filter. Runs one windowed

---
 rtl/adc_current_monitor.sv | 175 +++++++++++++++++
 tb/tb_adc_current_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_current_monitor.sv
// adc_current_monitor: one windowed acquisition per start request.
// Latches a channel and over-current threshold, issues 2**LOG2_N conversions to the
// AD7265 driver, and returns sum, truncated average, min, max and an over-current flag.
module adc_current_monitor #(
    parameter  int NCHAN  = 16,
    parameter  int DATA_W = 12,
    parameter  int LOG2_N = 4,
    localparam int CH_W   = $clog2(NCHAN),
    localparam int SUM_W  = DATA_W + LOG2_N
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   chan,
    input  logic              gate,
    input  logic [DATA_W-1:0] oc_thresh,
    output logic              adc_req,
    output logic [CH_W-2:0]   adc_addr,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_a,
    input  logic [DATA_W-1:0] adc_b,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [DATA_W-1:0] res_avg,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic              res_oc,
    output logic              aborted
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;

    typedef enum logic [1:0] {IDLE, ARM, SAMPLE, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [CH_W-1:0]   chan_q;
    logic [DATA_W-1:0] thresh_q;
    logic [SUM_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;
    logic              pending;

    logic              accept;
    logic              issue;
    logic              capture;
    logic              abort_now;
    logic              last;
    logic [DATA_W-1:0] sample;
    logic [SUM_W-1:0]  acc_next;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;

    // Selected sample and running statistics as they would be after capturing it
    always_comb begin
        sample   = chan_q[CH_W-1] ? adc_b : adc_a;
        acc_next = acc + SUM_W'(sample);
        min_next = (sample < min_q) ? sample : min_q;
        max_next = (sample > max_q) ? sample : max_q;
        last     = (count == CNT_W'(N - 1));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, control strobes and status outputs
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        abort_now  = 1'b0;
        busy       = (state != IDLE);
        res_valid  = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (gate) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                // Losing the gate wins over a capture or request in the same cycle
                if (!gate) begin
                    abort_now  = 1'b1;
                    state_next = IDLE;
                end else if (pending && adc_rdy && !adc_req) begin
                    capture = 1'b1;
                    if (last) begin
                        state_next = DONE;
                    end
                end else if (!pending && adc_rdy && (count < CNT_W'(N))) begin
                    issue = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window datapath, conversion handshake and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            chan_q   <= '0;
            thresh_q <= '0;
            acc      <= '0;
            count    <= '0;
            min_q    <= '1;
            max_q    <= '0;
            pending  <= 1'b0;
            adc_req  <= 1'b0;
            aborted  <= 1'b0;
            res_sum  <= '0;
            res_avg  <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_oc   <= 1'b0;
        end else begin
            adc_req <= issue;
            aborted <= abort_now;
            if (accept) begin
                chan_q   <= chan;
                thresh_q <= oc_thresh;
                acc      <= '0;
                count    <= '0;
                min_q    <= '1;
                max_q    <= '0;
                pending  <= 1'b0;
            end
            if (issue) begin
                pending <= 1'b1;
            end
            if (capture) begin
                acc     <= acc_next;
                count   <= count + CNT_W'(1);
                min_q   <= min_next;
                max_q   <= max_next;
                pending <= 1'b0;
                if (last) begin
                    res_sum <= acc_next;
                    res_avg <= acc_next[SUM_W-1:LOG2_N];
                    res_min <= min_next;
                    res_max <= max_next;
                    res_oc  <= (max_next > thresh_q);
                end
            end
            if (abort_now) begin
                pending <= 1'b0;
            end
        end
    end

    assign adc_addr = chan_q[CH_W-2:0];

endmodule

// File: tb/tb_adc_current_monitor.sv
// Testbench for adc_current_monitor: constant vectors, randomized windows against a
// reference model, and hand-written abort / DONE-hold / mid-window reset sequences.
module tb_adc_current_monitor;

    localparam int N = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start;
    logic [3:0]  chan;
    logic        gate;
    logic [11:0] oc_thresh;
    logic        adc_req;
    logic [2:0]  adc_addr;
    logic        adc_rdy;
    logic [11:0] adc_a;
    logic [11:0] adc_b;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic [11:0] res_avg;
    logic [11:0] res_min;
    logic [11:0] res_max;
    logic        res_oc;
    logic        aborted;

    int checks = 0;
    int errors = 0;

    adc_current_monitor #(.NCHAN(16), .DATA_W(12), .LOG2_N(4)) dut (
        .clock(clock), .reset(reset), .start(start), .chan(chan), .gate(gate),
        .oc_thresh(oc_thresh), .adc_req(adc_req), .adc_addr(adc_addr), .adc_rdy(adc_rdy),
        .adc_a(adc_a), .adc_b(adc_b), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_avg(res_avg), .res_min(res_min),
        .res_max(res_max), .res_oc(res_oc), .aborted(aborted)
    );

    always #5 clock = ~clock;

    // Behavioural AD7265 driver: serves the i-th request of a window from the sample arrays
    logic [11:0] a_vals [N];
    logic [11:0] b_vals [N];
    int max_lat = 0;
    int req_idx;
    int lat_cnt;

    always @(negedge clock) begin
        if (reset) begin
            adc_rdy = 1'b1;
            adc_a   = '0;
            adc_b   = '0;
            req_idx = 0;
            lat_cnt = 0;
        end else begin
            if (!busy) req_idx = 0;
            if (adc_req) begin
                adc_a   = a_vals[req_idx % N];
                adc_b   = b_vals[req_idx % N];
                req_idx = req_idx + 1;
                lat_cnt = int'($urandom_range(max_lat, 0));
                if (lat_cnt > 0) adc_rdy = 1'b0;
            end else if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) adc_rdy = 1'b1;
            end
        end
    end

    typedef struct {
        logic [3:0]  c;
        logic [11:0] th;
        int kind;
        int base;
        int spike;
        int e_sum;
        int e_avg;
        int e_min;
        int e_max;
        int e_oc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string tag, input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input int s, input int avg, input int mn,
                             input int mx, input int oc);
        check(tag, "sum", int'(res_sum), s);
        check(tag, "avg", int'(res_avg), avg);
        check(tag, "min", int'(res_min), mn);
        check(tag, "max", int'(res_max), mx);
        check(tag, "oc",  int'(res_oc),  oc);
    endtask

    task automatic check_zero(input string tag);
        check(tag, "ctrl", int'({adc_req, adc_addr, busy, res_valid, res_oc, aborted}), 0);
        check_res(tag, 0, 0, 0, 0, 0);
    endtask

    // Reference: statistics of the selected side of the sample arrays
    task automatic model(input logic [3:0] c, input logic [11:0] th, output int s,
                         output int avg, output int mn, output int mx, output int oc);
        s  = 0;
        mn = 4095;
        mx = 0;
        for (int i = 0; i < N; i++) begin
            int v;
            v = c[3] ? int'(b_vals[i]) : int'(a_vals[i]);
            s = s + v;
            if (v < mn) mn = v;
            if (v > mx) mx = v;
        end
        avg = s / N;
        oc  = (mx > int'(th)) ? 1 : 0;
    endtask

    task automatic fill(input int kind, input logic [3:0] c, input int base, input int spike);
        for (int i = 0; i < N; i++) begin
            int v;
            if (kind == 0)      v = base;
            else if (kind == 1) v = base + i;
            else                v = (i == 6) ? spike : base;
            if (c[3]) begin
                b_vals[i] = 12'(v);
                a_vals[i] = 12'(4000 - i);
            end else begin
                a_vals[i] = 12'(v);
                b_vals[i] = 12'(3000 + i);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            a_vals[i] = 12'($urandom);
            b_vals[i] = 12'($urandom);
        end
    endtask

    task automatic start_window(input logic [3:0] c, input logic [11:0] th);
        @(negedge clock);
        chan      = c;
        oc_thresh = th;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        chan      = 4'($urandom);
        oc_thresh = 12'($urandom);
    endtask

    task automatic wait_result(input string tag, input logic [2:0] exp_addr, output int cyc);
        int addr_ok;
        addr_ok = 1;
        cyc = 0;
        while (!res_valid && cyc < 3000) begin
            if (adc_addr !== exp_addr) addr_ok = 0;
            @(negedge clock);
            cyc++;
        end
        check(tag, "addr_hold", addr_ok, 1);
        check(tag, "done_timeout", int'(res_valid), 1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check(tag, "valid_after_hs", int'(res_valid), 0);
        check(tag, "busy_after_hs", int'(busy), 0);
    endtask

    task automatic run_random(input string tag, input int lat);
        logic [3:0]  c;
        logic [11:0] th;
        int s, avg, mn, mx, oc, cyc;
        c  = 4'($urandom);
        th = 12'($urandom_range(4095, 3000));
        fill_random();
        max_lat = lat;
        model(c, th, s, avg, mn, mx, oc);
        start_window(c, th);
        wait_result(tag, c[2:0], cyc);
        check_res(tag, s, avg, mn, mx, oc);
        handshake(tag);
    endtask

    initial begin
        int cyc, ok;
        int p_sum, p_avg, p_min, p_max, p_oc;
        logic [3:0]  hc;
        logic [11:0] hth;

        start = 1'b0; chan = '0; gate = 1'b1; oc_thresh = '0; res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_vals[i] = '0;
            b_vals[i] = '0;
        end

        vecs[0] = '{4'd3,  12'd200,  0, 100,  0, 1600,  100,  100,  100,  0};
        vecs[1] = '{4'd9,  12'd4095, 1, 0,    0, 120,   7,    0,    15,   0};
        vecs[2] = '{4'd2,  12'd50,   2, 10,  51, 201,   12,   10,   51,   1};
        vecs[3] = '{4'd2,  12'd50,   2, 10,  50, 200,   12,   10,   50,   0};
        vecs[4] = '{4'd15, 12'd4094, 0, 4095, 0, 65520, 4095, 4095, 4095, 1};
        vecs[5] = '{4'd0,  12'd0,    0, 0,    0, 0,     0,    0,    0,    0};

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            max_lat = (v == 0) ? 0 : 3;
            fill(vecs[v].kind, vecs[v].c, vecs[v].base, vecs[v].spike);
            start_window(vecs[v].c, vecs[v].th);
            wait_result($sformatf("vec%0d", v), vecs[v].c[2:0], cyc);
            if (v == 0) check("vec0", "latency_ok", int'(cyc <= 2 + 3 * N), 1);
            check_res($sformatf("vec%0d", v), vecs[v].e_sum, vecs[v].e_avg, vecs[v].e_min,
                      vecs[v].e_max, vecs[v].e_oc);
            handshake($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 16; r++) run_random($sformatf("rand%0d", r), r % 4);

        // Waiting in ARM without gate, then abort after five captures
        p_sum = int'(res_sum); p_avg = int'(res_avg); p_min = int'(res_min);
        p_max = int'(res_max); p_oc = int'(res_oc);
        fill(0, 4'd5, 7, 0);
        max_lat = 1;
        gate = 1'b0;
        start_window(4'd5, 12'd100);
        repeat (10) @(negedge clock);
        check("arm", "busy", int'(busy), 1);
        check("arm", "no_req", req_idx, 0);
        gate = 1'b1;
        cyc = 0;
        while (req_idx < 6 && cyc < 500) begin
            @(posedge clock);
            cyc++;
        end
        check("abort", "sixth_req", int'(req_idx >= 6), 1);
        @(negedge clock);
        gate = 1'b0;
        @(negedge clock);
        check("abort", "pulse", int'(aborted), 1);
        check("abort", "busy", int'(busy), 0);
        check("abort", "valid", int'(res_valid), 0);
        check_res("abort_keep", p_sum, p_avg, p_min, p_max, p_oc);
        @(negedge clock);
        check("abort", "pulse_end", int'(aborted), 0);
        gate = 1'b1;
        run_random("post_abort", 2);

        // Result held in DONE while the consumer stalls; starts and gate ignored
        hc = 4'd1; hth = 12'd300;
        fill(1, hc, 200, 0);
        max_lat = 2;
        model(hc, hth, p_sum, p_avg, p_min, p_max, p_oc);
        start_window(hc, hth);
        wait_result("hold", hc[2:0], cyc);
        check_res("hold_pre", p_sum, p_avg, p_min, p_max, p_oc);
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            start = (k % 3 == 0);
            chan  = 4'($urandom);
            gate  = (k % 2 == 1);
            @(negedge clock);
            if (res_valid !== 1'b1 || busy !== 1'b1 || adc_req !== 1'b0 ||
                int'(res_sum) != p_sum || int'(res_avg) != p_avg || int'(res_min) != p_min ||
                int'(res_max) != p_max || int'(res_oc) != p_oc || adc_addr !== hc[2:0])
                ok = 0;
        end
        start = 1'b0;
        gate  = 1'b1;
        check("hold", "stable", ok, 1);
        res_ready = 1'b1;
        start     = 1'b1;
        chan      = 4'd9;
        @(negedge clock);
        res_ready = 1'b0;
        start     = 1'b0;
        check("hold", "valid_after_hs", int'(res_valid), 0);
        check("hold", "start_on_hs_ignored", int'(busy), 0);
        repeat (3) @(negedge clock);
        check("hold", "still_idle", int'(busy), 0);
        run_random("after_hold", 1);

        // Reset while a conversion is outstanding
        fill_random();
        max_lat = 3;
        hc = 4'd12; hth = 12'd2000;
        model(hc, hth, p_sum, p_avg, p_min, p_max, p_oc);
        start_window(hc, hth);
        cyc = 0;
        while (req_idx < 3 && cyc < 500) begin
            @(posedge clock);
            cyc++;
        end
        check("mid_reset", "third_req", int'(req_idx >= 3), 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_zero("mid_reset");
        reset = 1'b0;
        @(negedge clock);
        start_window(hc, hth);
        wait_result("post_reset", hc[2:0], cyc);
        check_res("post_reset", p_sum, p_avg, p_min, p_max, p_oc);
        handshake("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
